// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } ctrl_state_e;

  // One bit per pipeline-register control, MSB first as they appear on the ports.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN      = 7'b1101010;
  localparam pipe_ctrl_t CTRL_HALT     = 7'b0000001;
  localparam pipe_ctrl_t CTRL_REDIRECT = 7'b1111110;
  localparam pipe_ctrl_t CTRL_LOAD_USE = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard compare between ID sources and EX load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  output logic              hazard_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign w_rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_memread_i && (ex_rd_i != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline with memory watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_br_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_en_o,
  output logic              idex_flush_o,
  output logic              exmem_en_o,
  output logic              memwb_bubble_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [WAIT_CNT_W-1:0] C_WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic       w_load_use;
  logic       w_freeze;
  pipe_ctrl_t w_ctrl;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .hazard_o     (w_load_use)
  );

  // An outstanding wait keeps the pipe frozen even if mem_req drops.
  always_comb begin
    w_freeze = 1'b0;
    case (state_q)
      RUN:     w_freeze = mem_req_i && !mem_ready_i;
      MWAIT:   w_freeze = !mem_ready_i;
      default: w_freeze = 1'b0;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!rst_n || (state_q == ERR) || w_freeze) begin
      w_ctrl = CTRL_HALT;
    end else if (ex_br_taken_i) begin
      w_ctrl = CTRL_REDIRECT;
    end else if (w_load_use) begin
      w_ctrl = CTRL_LOAD_USE;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d    = MWAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      MWAIT: begin
        if (mem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d    = ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ERR: begin
        state_d    = ERR;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!w_ctrl.pc_en && (state_q != ERR) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_en_o        = w_ctrl.pc_en;
  assign ifid_en_o      = w_ctrl.ifid_en;
  assign ifid_flush_o   = w_ctrl.ifid_flush;
  assign idex_en_o      = w_ctrl.idex_en;
  assign idex_flush_o   = w_ctrl.idex_flush;
  assign exmem_en_o     = w_ctrl.exmem_en;
  assign memwb_bubble_o = w_ctrl.memwb_bubble;
  assign mem_err_o      = (state_q == ERR);
  assign stall_count_o  = stall_count_q;

endmodule

`default_nettype wire
